// File: rtl/tile_line_fetcher_pkg.sv
// Shared constants and state encoding for the tile line fetcher and its pixel shifter.
// The tilemap is 40x30 tiles and the tile ROM returns one 16-pixel row of 4-bit colours per read.
package tile_line_fetcher_pkg;

  localparam int TILE_WIDTH       = 16;
  localparam int PIXEL_BITS       = 4;
  localparam int TILE_ROW_BITS    = 64;
  localparam int TILES_PER_ROW    = 40;
  localparam int MAP_ADDR_WIDTH   = 11;
  localparam int TILE_INDEX_WIDTH = 6;
  localparam int MAP_ROW_WIDTH    = 5;
  localparam int FETCH_LATENCY    = 4;
  localparam int COL_WIDTH        = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // The product is truncated to the map address width; rows past the map are not range-checked.
  function automatic logic [MAP_ADDR_WIDTH-1:0] rowBase(input logic [MAP_ROW_WIDTH-1:0] mapRow);
    return MAP_ADDR_WIDTH'(32'(mapRow) * 32'(TILES_PER_ROW));
  endfunction

endpackage

// File: rtl/tile_line_fetcher_shifter.sv
// Serialises one 64-bit tile row into 16 colour indices, most significant nibble first.
// A load on the cycle of pixel 15 keeps consecutive tiles gap-free; clear drops the stream at once.
module tile_pixel_shifter
  import tile_line_fetcher_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic [TILE_ROW_BITS-1:0] row_i,
  output logic                     pixel_valid_o,
  output logic [PIXEL_BITS-1:0]    pixel_o
);

  localparam logic [3:0] LAST_PIXEL = 4'(TILE_WIDTH - 1);

  logic [TILE_ROW_BITS-1:0] shift_q, shift_d;
  logic [3:0]               phase_q, phase_d;
  logic                     valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    phase_d = phase_q;
    valid_d = valid_q;
    if (clear_i) begin
      shift_d = '0;
      phase_d = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      shift_d = row_i;
      phase_d = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      shift_d = {shift_q[TILE_ROW_BITS-PIXEL_BITS-1:0], {PIXEL_BITS{1'b0}}};
      phase_d = phase_q + 4'd1;
      if (phase_q == LAST_PIXEL) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign pixel_valid_o = valid_q;
  assign pixel_o       = valid_q ? shift_q[TILE_ROW_BITS-1 -: PIXEL_BITS] : '0;

endmodule

// File: rtl/tile_line_fetcher.sv
// Walks one tilemap row per scanline, fetching a tile index and then its ROM row every 16 cycles.
// Map read, tile read and shifter load form a three-stage pipeline that lines up with the pixel stream.
module tile_line_fetcher
  import tile_line_fetcher_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        line_start,
  input  logic [MAP_ROW_WIDTH-1:0]    map_row,
  input  logic [3:0]                  row_in,
  output logic                        map_read,
  output logic [MAP_ADDR_WIDTH-1:0]   map_addr,
  input  logic [TILE_INDEX_WIDTH-1:0] map_data,
  output logic                        tile_read,
  output logic [TILE_INDEX_WIDTH-1:0] tile_index,
  output logic [3:0]                  row_index,
  input  logic [TILE_ROW_BITS-1:0]    tile_dout,
  output logic                        pixel_valid,
  output logic [PIXEL_BITS-1:0]       pixel,
  output logic                        line_done
);

  localparam logic [3:0]           LAST_PHASE = 4'(TILE_WIDTH - 1);
  localparam logic [3:0]           DONE_PHASE = 4'(FETCH_LATENCY - 2);
  localparam logic [COL_WIDTH-1:0] LAST_COL   = COL_WIDTH'(TILES_PER_ROW - 1);
  localparam logic [COL_WIDTH-1:0] COL_DONE   = COL_WIDTH'(TILES_PER_ROW);

  state_e                      state_q, state_d;
  logic                        map_read_q, map_read_d;
  logic [MAP_ADDR_WIDTH-1:0]   map_addr_q, map_addr_d;
  logic [COL_WIDTH-1:0]        col_q, col_d;
  logic [3:0]                  phase_q, phase_d;
  logic [3:0]                  row_index_q, row_index_d;
  logic                        pending_q, pending_d;
  logic                        load_q, load_d;
  logic                        line_done_q, line_done_d;

  // phase_q counts 0..15 starting the cycle after line_start; col_q reaching COL_DONE marks the drain.
  always_comb begin
    state_d     = state_q;
    map_read_d  = 1'b0;
    map_addr_d  = map_addr_q;
    col_d       = col_q;
    phase_d     = phase_q;
    row_index_d = row_index_q;
    pending_d   = map_read_q;
    load_d      = pending_q;
    line_done_d = 1'b0;
    if (line_start) begin
      state_d     = ACTIVE;
      map_read_d  = 1'b1;
      map_addr_d  = rowBase(map_row);
      col_d       = '0;
      phase_d     = '0;
      row_index_d = row_in;
      pending_d   = 1'b0;
      load_d      = 1'b0;
    end else begin
      case (state_q)
        ACTIVE: begin
          phase_d = phase_q + 4'd1;
          if (phase_q == LAST_PHASE) begin
            if (col_q < LAST_COL) begin
              map_read_d = 1'b1;
              map_addr_d = map_addr_q + MAP_ADDR_WIDTH'(1);
              col_d      = col_q + COL_WIDTH'(1);
            end else if (col_q == LAST_COL) begin
              col_d = COL_DONE;
            end
          end
          if (col_q == COL_DONE && phase_q == DONE_PHASE) begin
            line_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      map_read_q  <= 1'b0;
      map_addr_q  <= '0;
      col_q       <= '0;
      phase_q     <= '0;
      row_index_q <= '0;
      pending_q   <= 1'b0;
      load_q      <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_read_q  <= map_read_d;
      map_addr_q  <= map_addr_d;
      col_q       <= col_d;
      phase_q     <= phase_d;
      row_index_q <= row_index_d;
      pending_q   <= pending_d;
      load_q      <= load_d;
      line_done_q <= line_done_d;
    end
  end

  tile_pixel_shifter u_shifter (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear_i       (line_start),
    .load_i        (load_q),
    .row_i         (tile_dout),
    .pixel_valid_o (pixel_valid),
    .pixel_o       (pixel)
  );

  assign map_read   = map_read_q;
  assign map_addr   = map_addr_q;
  assign tile_read  = pending_q;
  assign tile_index = pending_q ? map_data : '0;
  assign row_index  = row_index_q;
  assign line_done  = line_done_q;

endmodule

// File: doc/tile_line_fetcher.md
Name: tile_line_fetcher

Overview:
Downstream consumer and driver of the tile ROM. On each scanline start it walks one screen row of the tilemap and reads each tile index from the tilemap RAM. It issues the matching tile ROM row read and serialises each returned 64-bit row (16 pixels x 4 bits) into one 4-bit colour index per clock, which feeds the palette/VGA output stage.

Parameters:
TILES_PER_ROW, 40, tiles per scanline (640/16)
MAP_ADDR_WIDTH, 11, tilemap RAM address width (40x30 map)
TILE_INDEX_WIDTH, 6, tile number width (64 tiles)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
line_start  input  1  one-cycle pulse; begins a scanline fetch
map_row  input  5  screen tile row for this line, sampled with line_start
row_in  input  4  pixel row within tile (0-15), sampled with line_start
map_read  output  1  tilemap RAM read strobe
map_addr  output  MAP_ADDR_WIDTH  tilemap RAM address
map_data  input  TILE_INDEX_WIDTH  tilemap RAM registered output, valid the cycle after map_read
tile_read  output  1  tile ROM read enable
tile_index  output  TILE_INDEX_WIDTH  tile ROM tile select
row_index  output  4  tile ROM row select
tile_dout  input  64  tile ROM registered output, valid the cycle after tile_read
pixel_valid  output  1  pixel holds an active pixel
pixel  output  4  colour index
line_done  output  1  one-cycle pulse after the last pixel of the line

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; shifter, column and phase counters cleared. Reset mid-line aborts the line with no line_done.
- States: IDLE, ACTIVE. Cycles are numbered from the line_start cycle, which is cycle 0.
- IDLE -> ACTIVE on line_start. Latch base = map_row*TILES_PER_ROW (truncated to MAP_ADDR_WIDTH, no range check), row_index = row_in, col = 0, phase = 0.
- Fetch for column k:
  - map_read=1 and map_addr=base+k (registered) in cycle 1+16k.
  - tile_read=1 in cycle 2+16k, with tile_index=map_data driven combinationally from the RAM output, gated by an internal pending flag.
  - tile_dout is loaded into the 64-bit shifter at the end of cycle 3+16k.
- Strobes are single-cycle and never asserted outside these slots. tile_index=0 when tile_read=0.
- row_index holds its latched value for the whole line and resets to 0.
- Serialiser: pixel_valid=1 for cycles 4 .. 3+16*TILES_PER_ROW.
  - Pixel order is MSB nibble first: pixel 0 = tile_dout[63:60], pixel 15 = tile_dout[3:0].
  - The shifter shifts left 4 per cycle.
  - The reload for tile k+1 coincides with the output of pixel 15 of tile k, so there are no gaps between tiles.
  - pixel=0 whenever pixel_valid=0.
- Fixed latency: line_start to first pixel is 4 cycles.
- End of line: after the fetch for col TILES_PER_ROW-1, no further map_read is issued. line_done=1 in cycle 4+16*TILES_PER_ROW, then return to IDLE.
- line_start while ACTIVE: abort the current line immediately (no line_done), relatch inputs and restart at cycle 0 timing. pixel_valid drops in cycles 1-3 of the restart.
- line_start coincident with line_done: line_done still pulses, and the new line starts.
- Address increment wraps modulo 2^MAP_ADDR_WIDTH.

Decomposition:
- Shared vga_defs include holds: TILE_WIDTH=16, PIXEL_BITS=4, TILE_ROW_BITS=64, TILES_PER_ROW, TILE_INDEX_WIDTH, FETCH_LATENCY=4, and the state encodings.
- One sub-module, tile_pixel_shifter: 64-bit load/shift register with a 4-bit phase counter and the pixel/pixel_valid outputs.
- Fetch sequencing and address generation stay in the top module.

Test Plan:
1. Reset behaviour: assert reset_n=0 mid-line at cycle 37 -> all outputs 0 the same cycle; no line_done; after release the block idles until line_start.
2. Single line: map_row=2, row_in=5, tilemap[80..119]=k mod 64, ROM model returns 64'h0123456789ABCDEF for every tile -> map_addr 80 in cycle 1, 81 in cycle 17; tile_index 0 in cycle 2; row_index=5 throughout; pixel sequence 0,1,...,F repeating from cycle 4 for 640 cycles; line_done in cycle 644.
3. Seamless tile boundary: tile 0 row = all 4'h3, tile 1 row = all 4'hC -> pixel=3 for cycles 4-19, C for cycles 20-35, pixel_valid never drops.
4. Restart: line_start again at cycle 100 with map_row=0 -> no line_done; map_addr=0 in cycle 101; first new pixel in cycle 104.
5. Boundary: map_row=29 -> first map_addr=1160, last map_addr=1199; line_start coincident with line_done -> both honoured and the next map_read follows one cycle later.
6. Strobe hygiene: across a full line, count map_read=40 and tile_read=40; neither is ever high in the same cycle as line_done or while IDLE.
